lockpick_hash_sched: RTL
========================

Name: lockpick_hash_sched

Overview:
- Arbiter and sequencer that shares one iterative Feistel hash engine among NUM_REQ game front-ends (players).
- Each front-end presents a 128-bit block (key_a ^ key_b). The scheduler:
  - grants requesters round-robin,
  - runs ROUNDS single-cycle Feistel rounds through the feistel_round sub-module,
  - compares the result against TARGET,
  - returns result, match flag and requester id.
- Tracks consecutive failures per requester and locks out any requester that reaches MAX_FAIL until it is explicitly cleared.

Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- ROUNDS, 3: Feistel rounds per hash, 1..7.
- MAX_FAIL, 3: consecutive mismatches that cause lockout, 1..7.
- TARGET, 128'hCAFEBABE_12345678_DEADBEEF_FEEDFACE: challenge value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  request per requester; level, held until gnt.
- req_data  in  NUM_REQ*128  block per requester; requester i uses slice [i*128 +: 128].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse on the capture cycle.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle result strobe.
- done_id  out  $clog2(NUM_REQ)  requester the result belongs to; valid with done.
- hash_out  out  128  final {A,B,C,D}; valid with done.
- match  out  1  hash_out == TARGET; valid with done.
- locked  out  NUM_REQ  per-requester lockout flag.
- clear_lock  in  NUM_REQ  one-cycle pulse; clears the fail count and lock of that requester.

Behaviour:
- Reset values: all outputs 0; rr pointer 0; fail counters 0; FSM in IDLE. Reset mid-hash aborts the hash with no done.
- FSM states are IDLE, ROUND, RESULT.
- IDLE:
  - Eligible set = req & ~locked.
  - Round-robin: search starts at rr_ptr. Winner w gets gnt[w]=1 this cycle.
  - Same cycle: {A,B,C,D} <= req_data[w] (A = bits 127:96); id <= w; rnd <= 0; rr_ptr <= w+1 mod NUM_REQ; go to ROUND.
  - No eligible requester: stay in IDLE.
- ROUND:
  - Each cycle, state <= feistel_round(state); rnd++.
  - After ROUNDS cycles, go to RESULT.
  - req changes are ignored.
- RESULT (one cycle):
  - done=1, hash_out=state, match=(state==TARGET), done_id=id.
  - Go to IDLE. Arbitration resumes the next cycle.
- Latency: gnt at cycle 0, done at cycle ROUNDS+1. Back-to-back grant spacing is ROUNDS+2 cycles.
- Round function (feistel_round, combinational; all arithmetic mod 2^32):
  - F = ((B^D) + (A|C)) ^ {C[15:0],D[15:0]}.
  - Rotate each byte of F left 1, then rotate the 32-bit word left 3.
  - Replace each byte b with SBOX[b[6:0]].
  - A' = rotl8(A^F); B' = rotl17(B); C' = C + A; D' = ~D ^ B. All right-hand sides use pre-round values.
- Fail tracking (updated in RESULT for done_id):
  - match=1: fail_cnt <= 0.
  - match=0: fail_cnt increments, saturating at MAX_FAIL.
  - locked[i] = (fail_cnt[i] == MAX_FAIL), registered.
- clear_lock[i] on the same cycle as a RESULT update for i: clear wins, fail_cnt=0, locked=0.
- A request that becomes locked while already granted still completes and reports normally.
- hash_out, match and done_id hold their last values after done, until the next RESULT.

Decomposition:
- Package lockpick_pkg holds:
  - the FSM state enum,
  - SBOX: 128 entries, the first 128 of the AES forward S-box (0x63, 0x7c, 0x77, 0x7b, ...),
  - the default TARGET constant,
  - rotl helper functions.
- Sub-module feistel_round: purely combinational, 128-bit in, 128-bit out. It is reused by any future unrolled hash variant.

Test Plan:
- Single-round check (ROUNDS=1, NUM_REQ=2): req[0] with all-zero data -> gnt=01 at t0, done at t2, hash_out=63636363_00000000_00000000_FFFFFFFF, done_id=0, match=0.
- Match path: TARGET overridden to the golden model's hash of 0x0123...CDEF with ROUNDS=3 -> done at t4 with match=1, and fail_cnt of that requester reset to 0.
- Round-robin fairness: req=11 held continuously -> grants alternate 01, 10, 01, 10, spaced ROUNDS+2 cycles apart; done_id alternates 0, 1.
- Lockout (MAX_FAIL=3): requester 1 issues 3 mismatching requests -> locked=10 after the third done; further req[1] receives no gnt while requester 0 is still served. clear_lock[1] -> locked=00 next cycle, and req[1] is granted.
- Simultaneous clear: clear_lock[1] asserted in the same cycle as requester 1's third failing RESULT -> locked[1] stays 0, fail_cnt=0.
- Reset mid-hash: rst_n low during ROUND -> all outputs 0 immediately; no done after release; a pending request is re-granted from rr_ptr=0.

Source files
------------

// File: rtl/lockpick_pkg.sv
// Shared types, constants and helpers for the lockpick hash scheduler.
package lockpick_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StResult} state_e;

    localparam logic [127:0] DEFAULT_TARGET = 128'hCAFEBABE_12345678_DEADBEEF_FEEDFACE;

    // First half of the AES forward S-box; indexed by the low 7 bits of a byte.
    localparam logic [7:0] SBOX [128] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [7:0] rotl8b(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b[6:0]];
    endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel round over a 128-bit {A,B,C,D} block.
module feistel_round
    import lockpick_pkg::*;
(
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    logic [31:0] a, b, c, d;
    logic [31:0] f_mix, f_byte, f_rot, f_sub;

    assign {a, b, c, d} = state_i;

    always_comb begin
        f_mix  = ((b ^ d) + (a | c)) ^ {c[15:0], d[15:0]};
        f_byte = '0;
        for (int i = 0; i < 4; i++) begin
            f_byte[i*8 +: 8] = rotl8b(f_mix[i*8 +: 8]);
        end
        f_rot = rotl32(f_byte, 3);
        f_sub = '0;
        for (int i = 0; i < 4; i++) begin
            f_sub[i*8 +: 8] = sbox_lookup(f_rot[i*8 +: 8]);
        end
    end

    assign state_o = {rotl32(a ^ f_sub, 8), rotl32(b, 17), c + a, ~d ^ b};

endmodule

// File: rtl/lockpick_hash_sched.sv
// Round-robin scheduler sharing one iterative Feistel hash among NUM_REQ requesters,
// with per-requester consecutive-failure lockout.
module lockpick_hash_sched
    import lockpick_pkg::*;
#(
    parameter int unsigned   NUM_REQ  = 2,
    parameter int unsigned   ROUNDS   = 3,
    parameter int unsigned   MAX_FAIL = 3,
    parameter logic [127:0]  TARGET   = DEFAULT_TARGET,
    localparam int unsigned  IdW      = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*128-1:0] req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   done,
    output logic [IdW-1:0]         done_id,
    output logic [127:0]           hash_out,
    output logic                   match,
    output logic [NUM_REQ-1:0]     locked,
    input  logic [NUM_REQ-1:0]     clear_lock
);

    state_e                     st_q, st_d;
    logic [127:0]               blk_q, blk_d, blk_rnd;
    logic [2:0]                 rnd_q, rnd_d;
    logic [IdW-1:0]             id_q, id_d, rr_q, rr_d, done_id_q, done_id_d;
    logic [127:0]               hash_q, hash_d;
    logic                       match_q, match_d;
    logic [NUM_REQ-1:0][2:0]    fail_q, fail_d;
    logic [NUM_REQ-1:0]         elig, gnt_raw;
    logic                       found, res_match;
    logic [IdW-1:0]             win;

    feistel_round u_round (
        .state_i (blk_q),
        .state_o (blk_rnd)
    );

    assign res_match = (blk_q == TARGET);

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            locked[i] = (fail_q[i] == 3'(MAX_FAIL));
        end
    end

    // Round-robin search starting at rr_q over unlocked requesters.
    always_comb begin
        int unsigned idx;
        elig  = req & ~locked;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_q) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = IdW'(idx);
            end
        end
    end

    always_comb begin
        st_d      = st_q;
        blk_d     = blk_q;
        rnd_d     = rnd_q;
        id_d      = id_q;
        rr_d      = rr_q;
        hash_d    = hash_q;
        match_d   = match_q;
        done_id_d = done_id_q;
        fail_d    = fail_q;
        gnt_raw   = '0;
        unique case (st_q)
            StIdle: begin
                if (found) begin
                    gnt_raw[win] = 1'b1;
                    blk_d        = req_data[32'(win)*128 +: 128];
                    id_d         = win;
                    rnd_d        = '0;
                    rr_d         = IdW'((32'(win) + 1) % NUM_REQ);
                    st_d         = StRound;
                end
            end
            StRound: begin
                blk_d = blk_rnd;
                rnd_d = rnd_q + 3'd1;
                if (rnd_q == 3'(ROUNDS - 1)) st_d = StResult;
            end
            StResult: begin
                hash_d    = blk_q;
                match_d   = res_match;
                done_id_d = id_q;
                if (res_match) begin
                    fail_d[id_q] = '0;
                end else if (fail_q[id_q] != 3'(MAX_FAIL)) begin
                    fail_d[id_q] = fail_q[id_q] + 3'd1;
                end
                st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
        // A clear in the same cycle as a result update takes priority.
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (clear_lock[i]) fail_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= StIdle;
            blk_q     <= '0;
            rnd_q     <= '0;
            id_q      <= '0;
            rr_q      <= '0;
            hash_q    <= '0;
            match_q   <= 1'b0;
            done_id_q <= '0;
            fail_q    <= '0;
        end else begin
            st_q      <= st_d;
            blk_q     <= blk_d;
            rnd_q     <= rnd_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            hash_q    <= hash_d;
            match_q   <= match_d;
            done_id_q <= done_id_d;
            fail_q    <= fail_d;
        end
    end

    // Result outputs are live during RESULT and held from the registers afterwards.
    assign gnt      = rst_n ? gnt_raw : '0;
    assign busy     = (st_q != StIdle);
    assign done     = (st_q == StResult);
    assign hash_out = done ? blk_q : hash_q;
    assign match    = done ? res_match : match_q;
    assign done_id  = done ? id_q : done_id_q;

endmodule
